mem_lsu: RTL

Load/store unit for the MEM stage of the 32-bit RISC-V core. It accepts one load or store per transaction from the EX/MEM pipeline register and drives a word-addressed request onto the dcache port. It waits for the dcache acknowledge, then returns sign- or zero-extended load data, or store completion, to the writeback side. It holds `stall` high while a transaction is outstanding so the pipeline freezes upstream.

---
 rtl/mem_lsu.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: one outstanding dcache access, lane steering, load extension, timeout abort.
// Optional macro LSU_MISALIGN_TRAP_EN turns misaligned half/word accesses into immediate error responses.
module mem_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic [4:0]  rsp_rd,
    output logic        rsp_err,
    output logic        stall
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT_CYCLES - 1);

    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   lane_be = 4'b0001 << off;
            2'b01:   lane_be = off[1] ? 4'b1100 : 4'b0011;
            default: lane_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] wd);
        case (size)
            2'b00:   lane_wdata = {4{wd[7:0]}};
            2'b01:   lane_wdata = {2{wd[15:0]}};
            default: lane_wdata = wd;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] rd_word, input logic [1:0] size,
                                                input logic [1:0] off, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = rd_word[7:0];
            2'd1:    b = rd_word[15:8];
            2'd2:    b = rd_word[23:16];
            default: b = rd_word[31:24];
        endcase
        h = off[1] ? rd_word[31:16] : rd_word[15:0];
        case (size)
            2'b00:   load_extend = uns ? {24'd0, b} : {{24{b[7]}}, b};
            2'b01:   load_extend = uns ? {16'd0, h} : {{16{h[15]}}, h};
            default: load_extend = rd_word;
        endcase
    endfunction

    // Requests that must be answered with an error and never reach the dcache.
    function automatic logic req_is_err(input logic [1:0] size, input logic [1:0] off);
        req_is_err = (size == 2'b11);
`ifdef LSU_MISALIGN_TRAP_EN
        if ((size == 2'b01) && off[0]) begin
            req_is_err = 1'b1;
        end else if ((size == 2'b10) && (off != 2'b00)) begin
            req_is_err = 1'b1;
        end else begin
            req_is_err = req_is_err;
        end
`endif
    endfunction

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [1:0]  off_q, off_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic [4:0]  rsp_rd_q, rsp_rd_d;
    logic        rsp_err_q, rsp_err_d;
    logic        handshake_s;

    assign req_ready   = (state_q != ST_ACCESS);
    assign handshake_s = req_valid && req_ready;
    assign mem_req     = (state_q == ST_ACCESS);
    assign mem_we      = we_q;
    assign mem_addr    = addr_q;
    assign mem_be      = be_q;
    assign mem_wdata   = wdata_q;
    assign rsp_valid   = (state_q == ST_RESP);
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_rd      = rsp_rd_q;
    assign rsp_err     = rsp_err_q;
    assign stall       = !reset && (handshake_s || (state_q == ST_ACCESS));

    // Next-state, request latching and response formation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        size_d      = size_q;
        uns_d       = uns_q;
        off_d       = off_q;
        rd_d        = rd_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_rd_d    = rsp_rd_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            ST_ACCESS: begin
                cnt_d = cnt_q + 8'd1;
                if (mem_ack) begin
                    state_d     = ST_RESP;
                    rsp_rdata_d = we_q ? 32'd0 : load_extend(mem_rdata, size_q, off_q, uns_q);
                    rsp_err_d   = 1'b0;
                    rsp_rd_d    = rd_q;
                end else if (cnt_q == LAST_CNT) begin
                    state_d     = ST_RESP;
                    rsp_rdata_d = 32'd0;
                    rsp_err_d   = 1'b1;
                    rsp_rd_d    = rd_q;
                end else begin
                    state_d = ST_ACCESS;
                end
            end
            ST_IDLE, ST_RESP: begin
                if (handshake_s) begin
                    cnt_d   = 8'd0;
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    off_d   = req_addr[1:0];
                    rd_d    = req_rd;
                    addr_d  = {req_addr[31:2], 2'b00};
                    wdata_d = lane_wdata(req_size, req_wdata);
                    be_d    = lane_be(req_size, req_addr[1:0]);
                    if (req_is_err(req_size, req_addr[1:0])) begin
                        state_d     = ST_RESP;
                        rsp_rdata_d = 32'd0;
                        rsp_err_d   = 1'b1;
                        rsp_rd_d    = req_rd;
                    end else begin
                        state_d = ST_ACCESS;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 8'd0;
            we_q        <= 1'b0;
            size_q      <= 2'd0;
            uns_q       <= 1'b0;
            off_q       <= 2'd0;
            rd_q        <= 5'd0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            be_q        <= 4'd0;
            rsp_rdata_q <= 32'd0;
            rsp_rd_q    <= 5'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            off_q       <= off_d;
            rd_q        <= rd_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_rd_q    <= rsp_rd_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

endmodule
